adder_arbiter: RTL and testbench

ADDER_ARBITER -- requirements
Module: adder_arbiter

---
 rtl/adder_arbiter_pkg.sv | 13 +
 rtl/adder_arbiter_rr_pick.sv | 32 +++
 rtl/adder_arbiter.sv | 92 +++++++++
 tb/tb_adder_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_arbiter_pkg.sv
// Shared defaults and state encoding for the round-robin adder arbiter.
package adder_arbiter_pkg;

   localparam int unsigned NREQ_DEF  = 4;
   localparam int unsigned WIDTH_DEF = 8;
   localparam int unsigned ID_W_DEF  = $clog2(NREQ_DEF);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_e;

endpackage

// File: rtl/adder_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request above last_grant, with wrap.
module rr_pick
   import adder_arbiter_pkg::*;
#(
   parameter int unsigned NREQ = NREQ_DEF,
   parameter int unsigned ID_W = ID_W_DEF
) (
   input  logic [NREQ-1:0] req,
   input  logic [ID_W-1:0] last_grant,
   output logic [NREQ-1:0] grant_oh,
   output logic [ID_W-1:0] grant_idx
);

   int unsigned idx;
   logic        found;

   always_comb begin
      grant_oh  = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = 0;
      for (int unsigned i = 1; i <= NREQ; i++) begin
         idx = (32'(last_grant) + i) % NREQ;
         if (!found && req[ID_W'(idx)]) begin
            found                  = 1'b1;
            grant_oh[ID_W'(idx)]   = 1'b1;
            grant_idx              = ID_W'(idx);
         end
      end
   end

endmodule

// File: rtl/adder_arbiter.sv
// Shares one registered adder among NREQ requesters with round-robin arbitration.
module adder_arbiter
   import adder_arbiter_pkg::*;
#(
   parameter int unsigned NREQ  = NREQ_DEF,
   parameter int unsigned WIDTH = WIDTH_DEF,
   parameter int unsigned ID_W  = $clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic [WIDTH:0]        res_sum,
   output logic [ID_W-1:0]       res_id
);

   localparam int unsigned SUM_W = WIDTH + 1;

   state_e            state_q, state_d;
   logic [SUM_W-1:0]  sum_q, sum_d;
   logic [ID_W-1:0]   id_q, id_d;
   logic [ID_W-1:0]   last_grant_q, last_grant_d;
   logic [NREQ-1:0]   grant_oh;
   logic [ID_W-1:0]   grant_idx;
   logic [WIDTH-1:0]  a_sel, b_sel;
   logic              can_accept, req_xfer, res_xfer;

   rr_pick #(
      .NREQ (NREQ),
      .ID_W (ID_W)
   ) u_rr_pick (
      .req        (req_valid),
      .last_grant (last_grant_q),
      .grant_oh   (grant_oh),
      .grant_idx  (grant_idx)
   );

   // One-hot operand mux driven by the picker grant
   always_comb begin
      a_sel = '0;
      b_sel = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (grant_oh[i]) begin
            a_sel = req_a[i*WIDTH +: WIDTH];
            b_sel = req_b[i*WIDTH +: WIDTH];
         end
      end
   end

   // Accept when empty or when the held result drains this cycle
   always_comb begin
      state_d      = state_q;
      sum_d        = sum_q;
      id_d         = id_q;
      last_grant_d = last_grant_q;
      can_accept   = rst_n && ((state_q == EMPTY) || res_ready);
      req_ready    = can_accept ? grant_oh : '0;
      req_xfer     = |req_ready;
      res_xfer     = (state_q == FULL) && res_ready;
      if (req_xfer) begin
         state_d      = FULL;
         sum_d        = SUM_W'(a_sel) + SUM_W'(b_sel);
         id_d         = grant_idx;
         last_grant_d = grant_idx;
      end else if (res_xfer) begin
         state_d = EMPTY;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= EMPTY;
         sum_q        <= '0;
         id_q         <= '0;
         last_grant_q <= ID_W'(NREQ - 1);
      end else begin
         state_q      <= state_d;
         sum_q        <= sum_d;
         id_q         <= id_d;
         last_grant_q <= last_grant_d;
      end
   end

   assign res_valid = (state_q == FULL);
   assign res_sum   = sum_q;
   assign res_id    = id_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Scoreboard bench for adder_arbiter: expected sums queued at grant, checked at drain.
module tb_adder_arbiter;

   typedef struct packed {
      logic [8:0] sum;
      logic [1:0] id;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req_valid;
   logic [3:0]  req_ready;
   logic [31:0] req_a, req_b;
   logic        res_valid;
   logic        res_ready;
   logic [8:0]  res_sum;
   logic [1:0]  res_id;

   logic [7:0]  a_op [4];
   logic [7:0]  b_op [4];
   exp_t        sb [$];
   int          total = 0;
   int          bad   = 0;

   assign req_a = {a_op[3], a_op[2], a_op[1], a_op[0]};
   assign req_b = {b_op[3], b_op[2], b_op[1], b_op[0]};

   adder_arbiter dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_sum   (res_sum),
      .res_id    (res_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #50000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic exp_t mk(input int i);
      exp_t e;
      e.sum = 9'(a_op[i]) + 9'(b_op[i]);
      e.id  = 2'(i);
      return e;
   endfunction

   task automatic test_reset();
      rst_n = 1'b0; req_valid = 4'b1111; res_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      total++;
      if (res_valid !== 1'b0 || res_sum !== 9'd0 || res_id !== 2'd0) begin
         bad++; $display("FAIL reset_out valid=%b sum=%h id=%0d exp 0/0/0", res_valid, res_sum, res_id);
      end
      total++;
      if (req_ready !== 4'b0000) begin
         bad++; $display("FAIL reset_ready got=%b exp=0000", req_ready);
      end
      tick();
      rst_n = 1'b1; req_valid = 4'b0000;
      @(negedge clk);
      total++;
      if (res_valid !== 1'b0) begin
         bad++; $display("FAIL reset_release valid=%b exp=0", res_valid);
      end
      tick();
   endtask

   task automatic test_single();
      exp_t e;
      a_op[0] = 8'd3; b_op[0] = 8'd4;
      req_valid = 4'b0001; res_ready = 1'b1;
      @(negedge clk);
      total++;
      if (req_ready !== 4'b0001) begin
         bad++; $display("FAIL single_ready got=%b exp=0001", req_ready);
      end
      e.sum = 9'd7; e.id = 2'd0; sb.push_back(e);
      tick();
      req_valid = 4'b0000;
      @(negedge clk);
      total++;
      if (sb.size() == 0 || res_valid !== 1'b1) begin
         bad++; $display("FAIL single_valid got=%b exp=1", res_valid);
      end else begin
         e = sb.pop_front();
         if (res_sum !== e.sum || res_id !== e.id) begin
            bad++; $display("FAIL single_res sum=%h id=%0d exp sum=%h id=%0d", res_sum, res_id, e.sum, e.id);
         end
      end
      tick();
   endtask

   task automatic test_boundary();
      exp_t e;
      a_op[2] = 8'hFF; b_op[2] = 8'hFF;
      req_valid = 4'b0100;
      @(negedge clk);
      total++;
      if (req_ready !== 4'b0100) begin
         bad++; $display("FAIL bound_ready got=%b exp=0100", req_ready);
      end
      e.sum = 9'h1FE; e.id = 2'd2; sb.push_back(e);
      tick();
      req_valid = 4'b0000;
      @(negedge clk);
      total++;
      if (sb.size() == 0 || res_valid !== 1'b1) begin
         bad++; $display("FAIL bound_valid got=%b exp=1", res_valid);
      end else begin
         e = sb.pop_front();
         if (res_sum !== e.sum || res_id !== e.id) begin
            bad++; $display("FAIL bound_res sum=%h id=%0d exp sum=%h id=%0d", res_sum, res_id, e.sum, e.id);
         end
      end
      tick();
   endtask

   task automatic test_round_robin();
      exp_t       e;
      logic [3:0] exp_rdy;
      for (int i = 0; i < 4; i++) begin
         a_op[i] = 8'(16*i + 5);
         b_op[i] = 8'(250 - 7*i);
      end
      // last grant is 2 here; serve requester 3 so the rotation starts at 0
      req_valid = 4'b1000;
      @(negedge clk);
      total++;
      if (req_ready !== 4'b1000) begin
         bad++; $display("FAIL rr_prime_ready got=%b exp=1000", req_ready);
      end
      sb.push_back(mk(3));
      tick();
      req_valid = 4'b1111;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         total++;
         if (sb.size() == 0 || res_valid !== 1'b1) begin
            bad++; $display("FAIL rr_valid k=%0d got=%b exp=1", k, res_valid);
         end else begin
            e = sb.pop_front();
            if (res_sum !== e.sum || res_id !== e.id) begin
               bad++; $display("FAIL rr_res k=%0d sum=%h id=%0d exp sum=%h id=%0d", k, res_sum, res_id, e.sum, e.id);
            end
         end
         exp_rdy = 4'b0001 << (k % 4);
         total++;
         if (req_ready !== exp_rdy) begin
            bad++; $display("FAIL rr_ready k=%0d got=%b exp=%b", k, req_ready, exp_rdy);
         end
         sb.push_back(mk(k % 4));
         tick();
      end
      req_valid = 4'b0000;
      @(negedge clk);
      total++;
      if (sb.size() == 0 || res_valid !== 1'b1) begin
         bad++; $display("FAIL rr_drain valid=%b exp=1", res_valid);
      end else begin
         e = sb.pop_front();
         if (res_sum !== e.sum || res_id !== e.id) begin
            bad++; $display("FAIL rr_drain_res sum=%h id=%0d exp sum=%h id=%0d", res_sum, res_id, e.sum, e.id);
         end
      end
      tick();
   endtask

   task automatic test_backpressure();
      exp_t e;
      exp_t held;
      req_valid = 4'b0001;
      @(negedge clk);
      total++;
      if (req_ready !== 4'b0001) begin
         bad++; $display("FAIL bp_ready0 got=%b exp=0001", req_ready);
      end
      held = mk(0);
      sb.push_back(held);
      tick();
      res_ready = 1'b0; req_valid = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         total++;
         if (req_ready !== 4'b0000 || res_valid !== 1'b1) begin
            bad++; $display("FAIL bp_stall k=%0d ready=%b valid=%b exp 0000/1", k, req_ready, res_valid);
         end
         total++;
         if (res_sum !== held.sum || res_id !== held.id) begin
            bad++; $display("FAIL bp_hold k=%0d sum=%h id=%0d exp sum=%h id=%0d", k, res_sum, res_id, held.sum, held.id);
         end
         tick();
      end
      res_ready = 1'b1;
      @(negedge clk);
      total++;
      if (sb.size() == 0 || res_valid !== 1'b1) begin
         bad++; $display("FAIL bp_release valid=%b exp=1", res_valid);
      end else begin
         e = sb.pop_front();
         if (res_sum !== e.sum || res_id !== e.id) begin
            bad++; $display("FAIL bp_release_res sum=%h id=%0d exp sum=%h id=%0d", res_sum, res_id, e.sum, e.id);
         end
      end
      total++;
      if (req_ready !== 4'b0010) begin
         bad++; $display("FAIL bp_refill_ready got=%b exp=0010", req_ready);
      end
      sb.push_back(mk(1));
      tick();
      req_valid = 4'b0000;
      @(negedge clk);
      total++;
      if (sb.size() == 0 || res_valid !== 1'b1) begin
         bad++; $display("FAIL bp_bubble valid=%b exp=1", res_valid);
      end else begin
         e = sb.pop_front();
         if (res_sum !== e.sum || res_id !== e.id) begin
            bad++; $display("FAIL bp_refill_res sum=%h id=%0d exp sum=%h id=%0d", res_sum, res_id, e.sum, e.id);
         end
      end
      tick();
   endtask

   task automatic test_sparse();
      exp_t e;
      req_valid = 4'b1001;
      @(negedge clk);
      total++;
      if (req_ready !== 4'b1000) begin
         bad++; $display("FAIL sparse_first got=%b exp=1000", req_ready);
      end
      sb.push_back(mk(3));
      tick();
      @(negedge clk);
      total++;
      if (sb.size() == 0 || res_valid !== 1'b1) begin
         bad++; $display("FAIL sparse_valid1 got=%b exp=1", res_valid);
      end else begin
         e = sb.pop_front();
         if (res_sum !== e.sum || res_id !== e.id) begin
            bad++; $display("FAIL sparse_res1 sum=%h id=%0d exp sum=%h id=%0d", res_sum, res_id, e.sum, e.id);
         end
      end
      total++;
      if (req_ready !== 4'b0001) begin
         bad++; $display("FAIL sparse_second got=%b exp=0001", req_ready);
      end
      sb.push_back(mk(0));
      tick();
      req_valid = 4'b0000;
      @(negedge clk);
      total++;
      if (sb.size() == 0 || res_valid !== 1'b1) begin
         bad++; $display("FAIL sparse_valid2 got=%b exp=1", res_valid);
      end else begin
         e = sb.pop_front();
         if (res_sum !== e.sum || res_id !== e.id) begin
            bad++; $display("FAIL sparse_res2 sum=%h id=%0d exp sum=%h id=%0d", res_sum, res_id, e.sum, e.id);
         end
      end
      tick();
   endtask

   task automatic test_reset_mid();
      exp_t e;
      req_valid = 4'b0010;
      @(negedge clk);
      total++;
      if (req_ready !== 4'b0010) begin
         bad++; $display("FAIL rmid_ready got=%b exp=0010", req_ready);
      end
      sb.push_back(mk(1));
      tick();
      req_valid = 4'b0000; res_ready = 1'b0;
      @(negedge clk);
      total++;
      if (res_valid !== 1'b1) begin
         bad++; $display("FAIL rmid_full got=%b exp=1", res_valid);
      end
      #2;
      rst_n = 1'b0; req_valid = 4'b1111; res_ready = 1'b1;
      #1;
      total++;
      if (res_valid !== 1'b0 || res_sum !== 9'd0 || res_id !== 2'd0 || req_ready !== 4'b0000) begin
         bad++; $display("FAIL rmid_async valid=%b sum=%h id=%0d ready=%b exp 0/0/0/0000",
                         res_valid, res_sum, res_id, req_ready);
      end
      sb.delete();
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      total++;
      if (req_ready !== 4'b0001) begin
         bad++; $display("FAIL rmid_prio got=%b exp=0001", req_ready);
      end
      sb.push_back(mk(0));
      tick();
      req_valid = 4'b0000;
      @(negedge clk);
      total++;
      if (sb.size() == 0 || res_valid !== 1'b1) begin
         bad++; $display("FAIL rmid_valid got=%b exp=1", res_valid);
      end else begin
         e = sb.pop_front();
         if (res_sum !== e.sum || res_id !== e.id) begin
            bad++; $display("FAIL rmid_res sum=%h id=%0d exp sum=%h id=%0d", res_sum, res_id, e.sum, e.id);
         end
      end
      tick();
   endtask

   initial begin
      rst_n = 1'b0; req_valid = 4'b0000; res_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         a_op[i] = 8'(i + 1);
         b_op[i] = 8'(i + 2);
      end
      test_reset();
      test_single();
      test_boundary();
      test_round_robin();
      test_backpressure();
      test_sparse();
      test_reset_mid();
      total++;
      if (sb.size() != 0) begin
         bad++; $display("FAIL sb_leftover entries=%0d exp=0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
